// File: rtl/pkt_xfer_ctrl.sv
// Packet transfer controller: a captured RX packet is handed to the SPI slave one byte per CS frame.
// In TX mode, SPI-written bytes are queued in a FIFO and serialized on bit_tick.
module pkt_xfer_ctrl #(
    parameter int PKT_BYTES   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode_rx,
    input  logic                   pkt_valid,
    input  logic [PKT_BYTES*8-1:0] pkt_data,
    input  logic                   spi_cs_n,
    input  logic [7:0]             spi_rx_byte,
    output logic [7:0]             spi_tx_byte,
    input  logic                   bit_tick,
    output logic                   tx_out,
    input  logic                   clr_status,
    output logic                   rx_busy,
    output logic                   rx_done,
    output logic                   rx_overrun,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_overflow,
    output logic                   fifo_full,
    output logic                   fifo_empty
);
    localparam int PKT_W = PKT_BYTES * 8;
    localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_WAIT_CS, R_XFER} rx_state_e;
    typedef enum logic {T_IDLE, T_SHIFT} tx_state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   cs_dly_q, cs_dly_d;
    logic                   pkt_sync_q, pkt_sync_d, pkt_dly_q, pkt_dly_d;
    logic                   mode_q, mode_d;
    rx_state_e              rx_state_q, rx_state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [PKT_W-1:0]       pkt_q, pkt_d;
    logic                   rx_done_q, rx_done_d, rx_overrun_q, rx_overrun_d;
    tx_state_e              tx_state_q, tx_state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   tx_out_q, tx_out_d, tx_done_q, tx_done_d;
    logic                   tx_overflow_q, tx_overflow_d;
    logic [7:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   fifo_full_q, fifo_full_d, fifo_empty_q, fifo_empty_d;

    logic       cs_last, cs_fall, cs_rise, pkt_rise, mode_chg, rx_act, tx_act;
    logic       push, pop, do_push, overrun_set, overflow_set;
    logic [7:0] fifo_head;

    assign cs_last   = cs_sync_q[SYNC_STAGES-1];
    assign cs_fall   = cs_dly_q & ~cs_last;
    assign cs_rise   = ~cs_dly_q & cs_last;
    assign pkt_rise  = pkt_sync_q & ~pkt_dly_q;
    assign mode_chg  = mode_rx ^ mode_q;
    assign rx_act    = mode_rx & ~mode_chg;
    assign tx_act    = ~mode_rx & ~mode_chg;
    assign fifo_head = fifo_mem[rd_ptr_q];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        cs_dly_d    = cs_last;
        pkt_sync_d  = pkt_valid;
        pkt_dly_d   = pkt_sync_q;
        mode_d      = mode_rx;
        rx_state_d  = rx_state_q;
        idx_d       = idx_q;
        pkt_d       = pkt_q;
        rx_done_d   = 1'b0;
        overrun_set = 1'b0;
        if (mode_chg) begin
            rx_state_d = R_IDLE;
            idx_d      = '0;
        end else if (rx_act) begin
            overrun_set = pkt_rise && (rx_state_q != R_IDLE);
            case (rx_state_q)
                R_IDLE: if (pkt_rise) begin
                    pkt_d      = pkt_data;
                    idx_d      = '0;
                    rx_state_d = R_WAIT_CS;
                end
                R_WAIT_CS: if (cs_fall) rx_state_d = R_XFER;
                R_XFER: if (cs_rise) begin
                    if (idx_q == LAST_IDX) begin
                        rx_done_d  = 1'b1;
                        rx_state_d = R_IDLE;
                    end else begin
                        // The outgoing byte always sits in the top 8 bits of the packet register.
                        idx_d      = idx_q + 1'b1;
                        pkt_d      = {pkt_q[PKT_W-9:0], 8'h00};
                        rx_state_d = R_WAIT_CS;
                    end
                end
                default: rx_state_d = R_IDLE;
            endcase
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        tx_out_d   = tx_out_q;
        tx_done_d  = 1'b0;
        pop        = 1'b0;
        if (mode_chg) begin
            tx_state_d = T_IDLE;
            bit_cnt_d  = '0;
            tx_out_d   = 1'b0;
        end else if (tx_act) begin
            case (tx_state_q)
                T_IDLE: begin
                    if (bit_tick) tx_out_d = 1'b0;
                    if (!fifo_empty_q) begin
                        pop        = 1'b1;
                        shift_d    = fifo_head;
                        bit_cnt_d  = '0;
                        tx_state_d = T_SHIFT;
                    end
                end
                T_SHIFT: if (bit_tick) begin
                    tx_out_d  = MSB_FIRST ? shift_q[7] : shift_q[0];
                    shift_d   = MSB_FIRST ? {shift_q[6:0], 1'b0} : {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        if (!fifo_empty_q) begin
                            pop     = 1'b1;
                            shift_d = fifo_head;
                        end else begin
                            tx_done_d  = 1'b1;
                            tx_state_d = T_IDLE;
                        end
                    end
                end
                default: tx_state_d = T_IDLE;
            endcase
        end
    end

    always_comb begin
        push         = cs_rise & tx_act;
        do_push      = push & (~fifo_full_q | pop);
        overflow_set = push & fifo_full_q & ~pop;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (mode_chg) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !pop)      count_d = count_q + 1'b1;
            else if (!do_push && pop) count_d = count_q - 1'b1;
        end
        fifo_full_d   = (count_d == FULL_CNT);
        fifo_empty_d  = (count_d == '0);
        rx_overrun_d  = overrun_set  ? 1'b1 : (clr_status ? 1'b0 : rx_overrun_q);
        tx_overflow_d = overflow_set ? 1'b1 : (clr_status ? 1'b0 : tx_overflow_q);
    end

    // NOTE: state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q     <= '1;
            cs_dly_q      <= 1'b1;
            pkt_sync_q    <= 1'b0;
            pkt_dly_q     <= 1'b0;
            mode_q        <= 1'b0;
            rx_state_q    <= R_IDLE;
            idx_q         <= '0;
            pkt_q         <= '0;
            rx_done_q     <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_state_q    <= T_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            tx_out_q      <= 1'b0;
            tx_done_q     <= 1'b0;
            tx_overflow_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fifo_full_q   <= 1'b0;
            fifo_empty_q  <= 1'b1;
        end else begin
            cs_sync_q     <= cs_sync_d;
            cs_dly_q      <= cs_dly_d;
            pkt_sync_q    <= pkt_sync_d;
            pkt_dly_q     <= pkt_dly_d;
            mode_q        <= mode_d;
            rx_state_q    <= rx_state_d;
            idx_q         <= idx_d;
            pkt_q         <= pkt_d;
            rx_done_q     <= rx_done_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_state_q    <= tx_state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            tx_out_q      <= tx_out_d;
            tx_done_q     <= tx_done_d;
            tx_overflow_q <= tx_overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fifo_full_q   <= fifo_full_d;
            fifo_empty_q  <= fifo_empty_d;
        end
    end

    // NOTE: FIFO storage is not reset; the count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr_q] <= spi_rx_byte;
    end

    assign spi_tx_byte = (rx_state_q == R_IDLE) ? 8'h00 : pkt_q[PKT_W-1 -: 8];
    assign rx_busy     = (rx_state_q != R_IDLE);
    assign rx_done     = rx_done_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_busy     = (tx_state_q == T_SHIFT);
    assign tx_done     = tx_done_q;
    assign tx_out      = tx_out_q;
    assign tx_overflow = tx_overflow_q;
    assign fifo_full   = fifo_full_q;
    assign fifo_empty  = fifo_empty_q;
endmodule

// File: tb/tb_pkt_xfer_ctrl.sv
// Self-checking bench for pkt_xfer_ctrl: randomized packets and TX bytes checked against
// a byte/bit-level reference model of the RX hand-off and the TX queue.
module tb_pkt_xfer_ctrl;
    localparam int PKT_BYTES   = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam bit MSB_FIRST   = 1'b1;
    localparam int SYNC_STAGES = 2;
    localparam logic [16:0] RESET_OUTS = 17'h00001;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   mode_rx = 1'b1;
    logic                   pkt_valid = 1'b0;
    logic [PKT_BYTES*8-1:0] pkt_data = '0;
    logic                   spi_cs_n = 1'b1;
    logic [7:0]             spi_rx_byte = 8'h00;
    logic [7:0]             spi_tx_byte;
    logic                   bit_tick = 1'b0;
    logic                   tx_out;
    logic                   clr_status = 1'b0;
    logic                   rx_busy, rx_done, rx_overrun;
    logic                   tx_busy, tx_done, tx_overflow, fifo_full, fifo_empty;

    int n_checks = 0;
    int n_errors = 0;
    int rx_done_cnt = 0;
    int tx_done_cnt = 0;

    pkt_xfer_ctrl #(
        .PKT_BYTES(PKT_BYTES), .FIFO_DEPTH(FIFO_DEPTH),
        .MSB_FIRST(MSB_FIRST), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode_rx(mode_rx), .pkt_valid(pkt_valid),
        .pkt_data(pkt_data), .spi_cs_n(spi_cs_n), .spi_rx_byte(spi_rx_byte),
        .spi_tx_byte(spi_tx_byte), .bit_tick(bit_tick), .tx_out(tx_out),
        .clr_status(clr_status), .rx_busy(rx_busy), .rx_done(rx_done),
        .rx_overrun(rx_overrun), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_overflow(tx_overflow), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_done === 1'b1) rx_done_cnt++;
        if (tx_done === 1'b1) tx_done_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] byte_of(input logic [PKT_BYTES*8-1:0] p, input int i);
        return 8'(p >> (8 * (PKT_BYTES - 1 - i)));
    endfunction

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        return 1'(b >> (MSB_FIRST ? (7 - k) : k));
    endfunction

    function automatic logic [16:0] outs();
        return {spi_tx_byte, tx_out, rx_busy, rx_done, rx_overrun,
                tx_busy, tx_done, tx_overflow, fifo_full, fifo_empty};
    endfunction

    task automatic cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // One chip-select frame; returns after the controller has acted on cs_rise.
    task automatic cs_frame(input logic [7:0] b);
        spi_rx_byte = b;
        spi_cs_n = 1'b0;
        cyc(SYNC_STAGES + 2);
        spi_cs_n = 1'b1;
        cyc(SYNC_STAGES + 1);
    endtask

    task automatic tick();
        bit_tick = 1'b1;
        cyc(1);
        bit_tick = 1'b0;
    endtask

    task automatic load_packet(input logic [PKT_BYTES*8-1:0] p);
        pkt_data = p;
        pkt_valid = 1'b1;
        cyc(2);
        pkt_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (outs() !== RESET_OUTS) begin n_errors++; $display("FAIL reset_outs: got %h want %h", outs(), RESET_OUTS); end
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        n_checks++; if (outs() !== RESET_OUTS) begin n_errors++; $display("FAIL post_reset_outs: got %h want %h", outs(), RESET_OUTS); end
    endtask

    task automatic test_rx_packet(input logic [PKT_BYTES*8-1:0] p);
        int d0;
        d0 = rx_done_cnt;
        pkt_data = p;
        pkt_valid = 1'b1;
        cyc(1);
        n_checks++; if (spi_tx_byte !== 8'h00) begin n_errors++; $display("FAIL rx_latency: got %h want 00", spi_tx_byte); end
        cyc(1);
        pkt_valid = 1'b0;
        for (int i = 0; i < PKT_BYTES; i++) begin
            n_checks++; if (spi_tx_byte !== byte_of(p, i)) begin n_errors++; $display("FAIL rx_byte%0d: got %h want %h", i, spi_tx_byte, byte_of(p, i)); end
            n_checks++; if (rx_busy !== 1'b1) begin n_errors++; $display("FAIL rx_busy%0d: got %b want 1", i, rx_busy); end
            cs_frame(8'($urandom));
            n_checks++; if (rx_done !== (i == PKT_BYTES - 1)) begin n_errors++; $display("FAIL rx_done%0d: got %b want %b", i, rx_done, (i == PKT_BYTES - 1)); end
            n_checks++; if (rx_busy !== (i != PKT_BYTES - 1)) begin n_errors++; $display("FAIL rx_busy_after%0d: got %b want %b", i, rx_busy, (i != PKT_BYTES - 1)); end
        end
        cyc(1);
        n_checks++; if (rx_done !== 1'b0) begin n_errors++; $display("FAIL rx_done_width: got %b want 0", rx_done); end
        n_checks++; if (rx_done_cnt !== d0 + 1) begin n_errors++; $display("FAIL rx_done_count: got %0d want %0d", rx_done_cnt - d0, 1); end
        n_checks++; if (spi_tx_byte !== 8'h00) begin n_errors++; $display("FAIL rx_idle_byte: got %h want 00", spi_tx_byte); end
    endtask

    task automatic test_rx_overrun();
        logic [PKT_BYTES*8-1:0] a;
        a = {$urandom(), $urandom()};
        load_packet(a);
        for (int i = 0; i < PKT_BYTES; i++) begin
            if (i == 3) begin
                n_checks++; if (rx_overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_pre: got %b want 0", rx_overrun); end
                load_packet({$urandom(), $urandom()});
                n_checks++; if (rx_overrun !== 1'b1) begin n_errors++; $display("FAIL overrun_set: got %b want 1", rx_overrun); end
            end
            if (i == 5) begin
                clr_status = 1'b1;
                cyc(1);
                clr_status = 1'b0;
                n_checks++; if (rx_overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_clr: got %b want 0", rx_overrun); end
                pkt_data = {$urandom(), $urandom()};
                pkt_valid = 1'b1;
                cyc(1);
                clr_status = 1'b1;
                cyc(1);
                clr_status = 1'b0;
                pkt_valid = 1'b0;
                n_checks++; if (rx_overrun !== 1'b1) begin n_errors++; $display("FAIL overrun_set_wins: got %b want 1", rx_overrun); end
            end
            n_checks++; if (spi_tx_byte !== byte_of(a, i)) begin n_errors++; $display("FAIL overrun_byte%0d: got %h want %h", i, spi_tx_byte, byte_of(a, i)); end
            cs_frame(8'h00);
        end
        n_checks++; if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL overrun_end_busy: got %b want 0", rx_busy); end
        clr_status = 1'b1;
        cyc(1);
        clr_status = 1'b0;
    endtask

    task automatic test_tx_msb();
        int d0;
        mode_rx = 1'b0;
        cyc(2);
        d0 = tx_done_cnt;
        cs_frame(8'hA5);
        cyc(1);
        n_checks++; if (tx_busy !== 1'b1) begin n_errors++; $display("FAIL tx_start_busy: got %b want 1", tx_busy); end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++; if (tx_out !== exp_bit(8'hA5, k)) begin n_errors++; $display("FAIL tx_a5_bit%0d: got %b want %b", k, tx_out, exp_bit(8'hA5, k)); end
            n_checks++; if (tx_done !== (k == 7)) begin n_errors++; $display("FAIL tx_a5_done%0d: got %b want %b", k, tx_done, (k == 7)); end
            cyc(3);
        end
        n_checks++; if (tx_out !== exp_bit(8'hA5, 7)) begin n_errors++; $display("FAIL tx_hold: got %b want %b", tx_out, exp_bit(8'hA5, 7)); end
        n_checks++; if (tx_done_cnt !== d0 + 1) begin n_errors++; $display("FAIL tx_a5_done_count: got %0d want 1", tx_done_cnt - d0); end
        tick();
        n_checks++; if (tx_out !== 1'b0) begin n_errors++; $display("FAIL tx_idle_zero: got %b want 0", tx_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q_m [$];
        logic [7:0] served [$];
        logic [7:0] b;
        bit         ser_busy;
        bit         ovf;
        bit         last;
        int         d0;
        ser_busy = 1'b0;
        ovf = 1'b0;
        d0 = tx_done_cnt;
        for (int n = 0; n < FIFO_DEPTH + 2; n++) begin
            b = 8'($urandom);
            cs_frame(b);
            if (q_m.size() < FIFO_DEPTH) q_m.push_back(b);
            else ovf = 1'b1;
            cyc(1);
            if (!ser_busy && q_m.size() > 0) begin
                served.push_back(q_m.pop_front());
                ser_busy = 1'b1;
            end
            n_checks++; if (fifo_full !== (q_m.size() == FIFO_DEPTH)) begin n_errors++; $display("FAIL b2b_full%0d: got %b want %b", n, fifo_full, (q_m.size() == FIFO_DEPTH)); end
            n_checks++; if (fifo_empty !== (q_m.size() == 0)) begin n_errors++; $display("FAIL b2b_empty%0d: got %b want %b", n, fifo_empty, (q_m.size() == 0)); end
            n_checks++; if (tx_overflow !== ovf) begin n_errors++; $display("FAIL b2b_overflow%0d: got %b want %b", n, tx_overflow, ovf); end
        end
        while (q_m.size() > 0) served.push_back(q_m.pop_front());
        for (int j = 0; j < served.size(); j++) begin
            for (int k = 0; k < 8; k++) begin
                last = (j == served.size() - 1) && (k == 7);
                tick();
                n_checks++; if (tx_out !== exp_bit(served[j], k)) begin n_errors++; $display("FAIL b2b_bit%0d_%0d: got %b want %b", j, k, tx_out, exp_bit(served[j], k)); end
                n_checks++; if (tx_busy !== !last) begin n_errors++; $display("FAIL b2b_busy%0d_%0d: got %b want %b", j, k, tx_busy, !last); end
                n_checks++; if (tx_done !== last) begin n_errors++; $display("FAIL b2b_done%0d_%0d: got %b want %b", j, k, tx_done, last); end
                cyc($urandom_range(0, 2));
            end
        end
        cyc(1);
        n_checks++; if (tx_done_cnt !== d0 + 1) begin n_errors++; $display("FAIL b2b_done_count: got %0d want 1", tx_done_cnt - d0); end
        n_checks++; if (fifo_empty !== 1'b1) begin n_errors++; $display("FAIL b2b_final_empty: got %b want 1", fifo_empty); end
    endtask

    task automatic test_mode_abort();
        logic [7:0] rb;
        int         rd0;
        int         td0;
        mode_rx = 1'b1;
        cyc(2);
        load_packet({$urandom(), $urandom()});
        cs_frame(8'h00);
        rb = 8'($urandom);
        spi_rx_byte = rb;
        spi_cs_n = 1'b0;
        cyc(SYNC_STAGES + 2);
        n_checks++; if (rx_busy !== 1'b1) begin n_errors++; $display("FAIL abort_pre_busy: got %b want 1", rx_busy); end
        rd0 = rx_done_cnt;
        mode_rx = 1'b0;
        cyc(1);
        n_checks++; if (rx_busy !== 1'b0) begin n_errors++; $display("FAIL abort_rx_busy: got %b want 0", rx_busy); end
        n_checks++; if (spi_tx_byte !== 8'h00) begin n_errors++; $display("FAIL abort_rx_byte: got %h want 00", spi_tx_byte); end
        spi_cs_n = 1'b1;
        cyc(SYNC_STAGES + 2);
        n_checks++; if (rx_done_cnt !== rd0) begin n_errors++; $display("FAIL abort_rx_done: got %0d pulses want 0", rx_done_cnt - rd0); end
        n_checks++; if (tx_overflow !== 1'b1) begin n_errors++; $display("FAIL abort_sticky_kept: got %b want 1", tx_overflow); end
        cs_frame(8'($urandom));
        cyc(1);
        n_checks++; if (fifo_empty !== 1'b0) begin n_errors++; $display("FAIL abort_queued: got %b want 0", fifo_empty); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (tx_out !== exp_bit(rb, k)) begin n_errors++; $display("FAIL abort_bit%0d: got %b want %b", k, tx_out, exp_bit(rb, k)); end
            cyc(1);
        end
        td0 = tx_done_cnt;
        mode_rx = 1'b1;
        cyc(1);
        n_checks++; if (tx_out !== 1'b0) begin n_errors++; $display("FAIL abort_tx_out: got %b want 0", tx_out); end
        n_checks++; if (tx_busy !== 1'b0) begin n_errors++; $display("FAIL abort_tx_busy: got %b want 0", tx_busy); end
        n_checks++; if (fifo_empty !== 1'b1) begin n_errors++; $display("FAIL abort_flush: got %b want 1", fifo_empty); end
        for (int k = 0; k < 6; k++) begin tick(); cyc(1); end
        n_checks++; if (tx_done_cnt !== td0) begin n_errors++; $display("FAIL abort_tx_done: got %0d pulses want 0", tx_done_cnt - td0); end
        clr_status = 1'b1;
        cyc(1);
        clr_status = 1'b0;
        n_checks++; if (tx_overflow !== 1'b0) begin n_errors++; $display("FAIL overflow_clr: got %b want 0", tx_overflow); end
    endtask

    task automatic test_reset_mid_op();
        int td0;
        mode_rx = 1'b0;
        cyc(2);
        for (int n = 0; n < 3; n++) begin cs_frame(8'($urandom)); cyc(1); end
        tick(); cyc(1); tick(); cyc(1);
        n_checks++; if ({tx_busy, fifo_empty} !== 2'b10) begin n_errors++; $display("FAIL rst_pre_state: got %b want 10", {tx_busy, fifo_empty}); end
        td0 = tx_done_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++; if (outs() !== RESET_OUTS) begin n_errors++; $display("FAIL rst_mid_outs: got %h want %h", outs(), RESET_OUTS); end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        for (int k = 0; k < 10; k++) begin tick(); cyc(2); end
        n_checks++; if ({tx_busy, tx_out, fifo_empty} !== 3'b001) begin n_errors++; $display("FAIL rst_no_resume: got %b want 001", {tx_busy, tx_out, fifo_empty}); end
        n_checks++; if (tx_done_cnt !== td0) begin n_errors++; $display("FAIL rst_no_done: got %0d pulses want 0", tx_done_cnt - td0); end
        cs_frame(8'($urandom));
        cyc(1);
        n_checks++; if (tx_busy !== 1'b1) begin n_errors++; $display("FAIL rst_new_push: got %b want 1", tx_busy); end
    endtask

    initial begin
        test_reset();
        test_rx_packet(64'h0123456789ABCDEF);
        for (int r = 0; r < 3; r++) test_rx_packet({$urandom(), $urandom()});
        test_rx_overrun();
        test_tx_msb();
        test_back_to_back();
        test_mode_abort();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
